// File: rtl/arith_unit_mc_pkg.sv
// Shared types for the multi-cycle arithmetic unit: opcodes and FSM states.
package arith_unit_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MAC  = 2'b10,
    OP_ABSD = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/arith_unit_mc_if.sv
// Operand/result handshake bundle between the register file side (master)
// and the arithmetic unit (slave).
interface arith_unit_mc_if
  import arith_unit_pkg::*;
#(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  op_t          op;
  logic [W-1:0] x2;
  logic [W-1:0] x1;
  logic [W-1:0] x0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid, op, x2, x1, x0, out_ready,
    input  in_ready, out_valid, f, ovf, busy
  );

  modport slave (
    input  in_valid, op, x2, x1, x0, out_ready,
    output in_ready, out_valid, f, ovf, busy
  );
endinterface

// File: rtl/arith_unit_mc_shift_add_mul.sv
// Iterative unsigned multiplier: the first partial product is folded in at
// start, then one more per cycle; done is high during the W-th cycle after
// start, when prod already holds the full product.
module shift_add_mul #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] prod,
  output logic           done
);
  localparam int CNT_W = $clog2(W + 1);

  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_a;
  logic [W-1:0]   r_b;
  logic [CNT_W-1:0] r_cnt;
  logic           r_run;

  assign done = r_run && (r_cnt == CNT_W'(W));
  assign prod = r_acc;

  // Shift-add datapath: multiplicand moves left, multiplier bits move right.
  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_acc <= b[0] ? {{W{1'b0}}, a} : '0;
      r_a   <= {{(W-1){1'b0}}, a, 1'b0};
      r_b   <= b >> 1;
      r_cnt <= CNT_W'(1);
      r_run <= 1'b1;
    end else if (r_run) begin
      if (done) begin
        r_run <= 1'b0;
      end else begin
        if (r_b[0]) r_acc <= r_acc + r_a;
        r_a   <= r_a << 1;
        r_b   <= r_b >> 1;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/arith_unit_mc.sv
// Multi-cycle 3-operand arithmetic unit. ADD/SUB/ABSD resolve in the accept
// cycle; MAC runs the shift-add multiplier for W cycles before DONE.
module arith_unit_mc
  import arith_unit_pkg::*;
#(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  arith_unit_mc_if.slave   bus
);
  localparam int RW = 2 * W + 1;

  state_t         r_state;
  state_t         w_state_nx;
  logic [W-1:0]   r_f;
  logic           r_ovf;
  logic [W-1:0]   r_x0;

  logic           w_accept;
  logic           w_mul_start;
  logic           w_mul_done;
  logic [2*W-1:0] w_prod;
  logic [RW-1:0]  w_x2e, w_x1e, w_x0e;
  logic [RW-1:0]  w_res;
  logic           w_ovf;
  logic [RW-1:0]  w_mac;

  assign w_accept    = (r_state == IDLE) && bus.in_valid;
  assign w_mul_start = w_accept && (bus.op == OP_MAC);

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.f         = r_f;
  assign bus.ovf       = r_ovf;

  assign w_x2e = RW'(bus.x2);
  assign w_x1e = RW'(bus.x1);
  assign w_x0e = RW'(bus.x0);
  assign w_mac = RW'(w_prod) + RW'(r_x0);

  shift_add_mul #(.W(W)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_mul_start),
    .a     (bus.x2),
    .b     (bus.x1),
    .prod  (w_prod),
    .done  (w_mul_done)
  );

  // Single-cycle datapath for ADD/SUB/ABSD, evaluated on the presented operands.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (bus.op)
      OP_ADD: begin
        w_res = w_x2e + w_x1e + w_x0e;
        w_ovf = |w_res[RW-1:W];
      end
      OP_SUB: begin
        w_res = w_x2e - w_x1e - w_x0e;
        w_ovf = (w_x1e + w_x0e) > w_x2e;
      end
      OP_ABSD: begin
        w_res = ((w_x2e >= w_x1e) ? (w_x2e - w_x1e) : (w_x1e - w_x2e)) + w_x0e;
        w_ovf = |w_res[RW-1:W];
      end
      default: begin
        w_res = '0;
        w_ovf = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state logic; in_valid is only looked at in IDLE.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_accept)      w_state_nx = (bus.op == OP_MAC) ? CALC : DONE;
      CALC:    if (w_mul_done)    w_state_nx = DONE;
      DONE:    if (bus.out_ready) w_state_nx = IDLE;
      default:                    w_state_nx = IDLE;
    endcase
  end

  // Result registers: written only on DONE entry, held through DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f   <= '0;
      r_ovf <= 1'b0;
      r_x0  <= '0;
    end else begin
      if (w_accept) begin
        r_x0 <= bus.x0;
        if (bus.op != OP_MAC) begin
          r_f   <= w_res[W-1:0];
          r_ovf <= w_ovf;
        end
      end
      if ((r_state == CALC) && w_mul_done) begin
        r_f   <= w_mac[W-1:0];
        r_ovf <= |w_mac[RW-1:W];
      end
    end
  end
endmodule
